// File: rtl/spi_reg_ctrl.sv
// Command/register controller behind the SPI slave shifter: decodes command/data pairs,
// owns MODE/GPIO registers, loads read responses. Optional write timeout: SPI_CMD_TIMEOUT_EN.
module spi_reg_ctrl #(
    parameter int unsigned GPIO_W         = 8,
    parameter logic [7:0]  MODE_RST       = 8'h00,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    input  logic              frame_active,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [7:0]        tx_byte,
    output logic              tx_load,
    output logic [7:0]        mode,
    output logic [GPIO_W-1:0] gpio_out,
    output logic [GPIO_W-1:0] gpio_oe,
    output logic              soft_rst,
    output logic              err,
    output logic              busy
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        RSP   = 2'd2
    } state_t;

    localparam logic [2:0] A_CTRL = 3'd0;
    localparam logic [2:0] A_MODE = 3'd1;
    localparam logic [2:0] A_GOUT = 3'd2;
    localparam logic [2:0] A_GOE  = 3'd3;
    localparam logic [2:0] A_GIN  = 3'd4;
    localparam logic [2:0] A_STAT = 3'd5;

    state_t            state_q, state_d;
    logic [2:0]        addr_q, addr_d;
    logic [2:0]        status_q, status_d;
    logic [7:0]        tx_byte_q, tx_byte_d;
    logic              tx_load_q, tx_load_d;
    logic [7:0]        mode_q, mode_d;
    logic [GPIO_W-1:0] gout_q, gout_d;
    logic [GPIO_W-1:0] goe_q, goe_d;
    logic              soft_rst_q, soft_rst_d;
    logic              frame_q;

    logic              frame_fall;
    logic              rx_acc;
    logic              cmd_legal;
    logic              tmo_hit;
    logic [7:0]        rd_val;
    logic [2:0]        err_set;

    assign frame_fall = frame_q & ~frame_active;
    // A byte completing in the cycle slave-select drops still belongs to the frame.
    assign rx_acc     = rx_valid & (frame_active | frame_q);
    assign cmd_legal  = (rx_byte[6:3] == 4'd0) && (rx_byte[2:0] <= A_STAT);

    always_comb begin
        rd_val = '0;
        case (rx_byte[2:0])
            A_MODE:  rd_val = mode_q;
            A_GOUT:  rd_val = 8'(gout_q);
            A_GOE:   rd_val = 8'(goe_q);
            A_GIN:   rd_val = 8'(gpio_in);
            A_STAT:  rd_val = {5'd0, status_q};
            default: rd_val = '0;
        endcase
    end

`ifdef SPI_CMD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;

    assign tmo_cnt_d = (state_q == WDATA) ? tmo_cnt_q + CNT_W'(1) : '0;
    assign tmo_hit   = (state_q == WDATA) && (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        tx_byte_d  = tx_byte_q;
        tx_load_d  = 1'b0;
        soft_rst_d = 1'b0;
        mode_d     = mode_q;
        gout_d     = gout_q;
        goe_d      = goe_q;
        err_set    = '0;
        // Read-to-clear takes effect at the end of the tx_load cycle; new errors OR in below.
        status_d   = (tx_load_q && addr_q == A_STAT) ? '0 : status_q;

        if (rx_acc) begin
            case (state_q)
                IDLE: begin
                    if (!cmd_legal) begin
                        err_set[0] = 1'b1;
                    end else begin
                        addr_d = rx_byte[2:0];
                        if (rx_byte[7]) begin
                            state_d = WDATA;
                        end else begin
                            state_d   = RSP;
                            tx_byte_d = rd_val;
                            tx_load_d = 1'b1;
                        end
                    end
                end
                WDATA: begin
                    state_d = IDLE;
                    case (addr_q)
                        A_CTRL: begin
                            if (rx_byte[0]) begin
                                mode_d     = MODE_RST;
                                gout_d     = '0;
                                goe_d      = '0;
                                status_d   = '0;
                                soft_rst_d = 1'b1;
                            end
                        end
                        A_MODE:  mode_d = rx_byte;
                        A_GOUT:  gout_d = rx_byte[GPIO_W-1:0];
                        A_GOE:   goe_d  = rx_byte[GPIO_W-1:0];
                        default: err_set[0] = 1'b1;
                    endcase
                end
                default: state_d = IDLE;
            endcase
        end

        if (frame_fall) begin
            if (state_d == WDATA) begin
                err_set[1] = 1'b1;
                state_d    = IDLE;
            end else if (state_d == RSP) begin
                state_d = IDLE;
            end
        end

        if (state_d == WDATA && tmo_hit) begin
            err_set[2] = 1'b1;
            state_d    = IDLE;
        end

        status_d = status_d | err_set;
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            status_q   <= '0;
            tx_byte_q  <= '0;
            tx_load_q  <= 1'b0;
            mode_q     <= MODE_RST;
            gout_q     <= '0;
            goe_q      <= '0;
            soft_rst_q <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            status_q   <= status_d;
            tx_byte_q  <= tx_byte_d;
            tx_load_q  <= tx_load_d;
            mode_q     <= mode_d;
            gout_q     <= gout_d;
            goe_q      <= goe_d;
            soft_rst_q <= soft_rst_d;
            frame_q    <= frame_active;
        end
    end

    assign tx_byte  = tx_byte_q;
    assign tx_load  = tx_load_q;
    assign mode     = mode_q;
    assign gpio_out = gout_q;
    assign gpio_oe  = goe_q;
    assign soft_rst = soft_rst_q;
    assign err      = |status_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench for spi_reg_ctrl: transaction-level model compared every cycle,
// directed literal checks, then randomized command/data/frame traffic.
`timescale 1ns/1ps
module tb_spi_reg_ctrl;
    localparam logic [7:0] MODE_RST = 8'hA5;
    localparam int         TMO      = 16;
    localparam int         P_IDLE   = 0;
    localparam int         P_WAIT   = 1;
    localparam int         P_RESP   = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    logic       frame_active = 1'b0;
    logic [7:0] gpio_in = 8'h00;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic [7:0] mode;
    logic [7:0] gpio_out;
    logic [7:0] gpio_oe;
    logic       soft_rst;
    logic       err;
    logic       busy;

    spi_reg_ctrl #(
        .GPIO_W        (8),
        .MODE_RST      (MODE_RST),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .sys_clk     (clk),
        .rst         (rst_n),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .frame_active(frame_active),
        .gpio_in     (gpio_in),
        .tx_byte     (tx_byte),
        .tx_load     (tx_load),
        .mode        (mode),
        .gpio_out    (gpio_out),
        .gpio_oe     (gpio_oe),
        .soft_rst    (soft_rst),
        .err         (err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: register file, pending write address, pending response.
    int m_mode, m_gout, m_goe, m_status, m_tx, m_txload, m_soft;
    int m_phase, m_waddr, m_raddr, m_wcnt;
    bit m_fa_prev;

    function automatic int reg_value(input int a, input int st);
        case (a)
            1:       return m_mode;
            2:       return m_gout;
            3:       return m_goe;
            4:       return int'(gpio_in);
            5:       return st;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = MODE_RST; m_gout = 0; m_goe = 0; m_status = 0;
        m_tx = 0; m_txload = 0; m_soft = 0;
        m_phase = P_IDLE; m_waddr = 0; m_raddr = 0; m_wcnt = 0; m_fa_prev = 0;
    endtask

    task automatic model_step();
        bit fall, acc;
        int s_old, nxt, raise, a;
        fall  = m_fa_prev && !frame_active;
        acc   = rx_valid && (frame_active || m_fa_prev);
        s_old = m_status;
        nxt   = (m_txload == 1 && m_raddr == 5) ? 0 : s_old;
        raise = 0;
        m_txload = 0;
        m_soft   = 0;
        if (acc) begin
            if (m_phase == P_IDLE) begin
                a = int'(rx_byte & 8'h07);
                if ((rx_byte & 8'h78) != 0 || a > 5) raise |= 1;
                else if (rx_byte[7]) begin
                    m_phase = P_WAIT; m_waddr = a; m_wcnt = 0;
                end else begin
                    m_phase = P_RESP; m_raddr = a; m_txload = 1; m_tx = reg_value(a, s_old);
                end
            end else if (m_phase == P_WAIT) begin
                m_phase = P_IDLE;
                case (m_waddr)
                    0: if (rx_byte[0]) begin
                        m_mode = MODE_RST; m_gout = 0; m_goe = 0; nxt = 0; m_soft = 1;
                    end
                    1: m_mode = int'(rx_byte);
                    2: m_gout = int'(rx_byte);
                    3: m_goe  = int'(rx_byte);
                    default: raise |= 1;
                endcase
            end else begin
                m_phase = P_IDLE;
            end
        end else if (m_phase == P_WAIT && !fall) begin
            m_wcnt++;
`ifdef SPI_CMD_TIMEOUT_EN
            if (m_wcnt == TMO) begin
                raise |= 4;
                m_phase = P_IDLE;
            end
`endif
        end
        if (fall) begin
            if (m_phase == P_WAIT) begin
                raise |= 2;
                m_phase = P_IDLE;
            end else if (m_phase == P_RESP) begin
                m_phase = P_IDLE;
            end
        end
        m_status  = nxt | raise;
        m_fa_prev = frame_active;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        check("cyc_tx_load", tx_load, m_txload);
        check("cyc_tx_byte", tx_byte, m_tx);
        check("cyc_mode", mode, m_mode);
        check("cyc_gpio_out", gpio_out, m_gout);
        check("cyc_gpio_oe", gpio_oe, m_goe);
        check("cyc_soft_rst", soft_rst, m_soft);
        check("cyc_err", err, (m_status != 0) ? 1 : 0);
        check("cyc_busy", busy, (m_phase != P_IDLE) ? 1 : 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] b;
        #1 rst_n = 1'b0;
        #1;
        check("rst_mode", mode, 8'hA5);
        check("rst_gout", gpio_out, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        #10;
        rst_n = 1'b1;
        frame_active = 1'b1;
        tick();

        send(8'h81);
        check("wr_busy_mid", busy, 1);
        tick();
        send(8'h5A);
        check("wr_mode", mode, 8'h5A);
        check("wr_busy_end", busy, 0);
        tick();

        gpio_in = 8'hC3;
        tick();
        send(8'h04);
        check("rd_gin_load", tx_load, 1);
        check("rd_gin_byte", tx_byte, 8'hC3);
        tick();
        check("rd_load_once", tx_load, 0);
        check("rd_busy_rsp", busy, 1);
        send(8'h00);
        check("rd_busy_idle", busy, 0);
        tick();

        send(8'h82);
        frame_active = 1'b0;
        tick();
        check("abort_gout", gpio_out, 0);
        check("abort_err", err, 1);
        frame_active = 1'b1;
        tick();
        send(8'h05);
        check("stat_abort", tx_byte, 8'h02);
        tick();
        check("stat_cleared", err, 0);
        send(8'h00);
        tick();
        send(8'h05);
        check("stat_rd2", tx_byte, 8'h00);
        tick();
        send(8'h00);
        tick();

        send(8'hC2);
        check("ill_err", err, 1);
        check("ill_idle", busy, 0);
        tick();
        send(8'h05);
        check("ill_stat", tx_byte, 8'h01);
        tick();
        send(8'h00);
        tick();
        send(8'h84);
        tick();
        send(8'hFF);
        check("ill_wr_err", err, 1);
        check("ill_wr_mode", mode, 8'h5A);
        tick();
        send(8'h05);
        check("ill_wr_stat", tx_byte, 8'h01);
        tick();
        send(8'h00);
        tick();

        send(8'h82); tick(); send(8'hAA); tick();
        check("pre_srst_gout", gpio_out, 8'hAA);
        send(8'hC2); tick();
        send(8'h80); tick();
        send(8'h01);
        check("srst_pulse", soft_rst, 1);
        check("srst_gout", gpio_out, 0);
        check("srst_mode", mode, 8'hA5);
        check("srst_err", err, 0);
        tick();
        check("srst_once", soft_rst, 0);

`ifdef SPI_CMD_TIMEOUT_EN
        send(8'h83);
        repeat (TMO - 1) tick();
        check("tmo_still_busy", busy, 1);
        tick();
        check("tmo_idle", busy, 0);
        send(8'h05);
        check("tmo_stat", tx_byte, 8'h04);
        tick();
        send(8'h00);
        tick();
`endif

        send(8'h81); tick(); send(8'h33); tick();
        send(8'h83); tick(); send(8'h0F); tick();
        send(8'h81);
        check("rstmid_busy", busy, 1);
        #3 rst_n = 1'b0;
        #1;
        check("rstmid_busy0", busy, 0);
        check("rstmid_mode", mode, 8'hA5);
        check("rstmid_goe", gpio_oe, 0);
        check("rstmid_txb", tx_byte, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        tick();

        for (int i = 0; i < 3000; i++) begin
            gpio_in = 8'($urandom);
            if (frame_active) begin
                if ($urandom_range(0, 39) == 0) frame_active = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                frame_active = 1'b1;
            end
            rx_valid = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) < 6) begin
                b = {1'($urandom), 4'b0000, 3'($urandom_range(0, 5))};
            end else begin
                b = 8'($urandom);
            end
            rx_byte = b;
            tick();
        end
        rx_valid = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
Command and register controller behind the SPI slave shifter in the sbasu3_top datapath.
- Consumes received bytes from the shifter and decodes command/data byte pairs.
- Owns the MODE, GPIO output and GPIO output-enable registers.
- Loads response bytes back into the shifter for reads.
- Sequences soft-reset and reports protocol errors.

Parameters:
GPIO_W, 8, width of the gpio_in, gpio_out and gpio_oe buses (range 1..8; register bytes are zero-extended).
MODE_RST, 8'h00, reset/soft-reset value of the mode register.
TIMEOUT_CYCLES, 1024, sys_clk cycles allowed between a write command byte and its data byte (used only with the optional feature).

Ports:
sys_clk  in  1  system clock; all logic on the rising edge
rst  in  1  asynchronous active-low reset
rx_valid  in  1  one-cycle pulse: rx_byte holds a complete received byte
rx_byte  in  8  received byte from the SPI shifter
frame_active  in  1  slave-select level, already synchronised to sys_clk (1 = frame in progress)
gpio_in  in  GPIO_W  external GPIO input levels
tx_byte  out  8  response byte presented to the shifter
tx_load  out  1  one-cycle pulse: shifter loads tx_byte
mode  out  8  mode register
gpio_out  out  GPIO_W  GPIO output register
gpio_oe  out  GPIO_W  GPIO output-enable register
soft_rst  out  1  one-cycle soft-reset pulse to the rest of the design
err  out  1  OR of the status error bits
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0), applied immediately and asynchronously:
  - state=IDLE.
  - tx_byte, tx_load, gpio_out, gpio_oe, soft_rst, status = 0.
  - mode=MODE_RST.
- Command byte format: [7]=1 write / 0 read; [6:3] must be 0; [2:0]=address.
- Address map:
  - 0 CTRL: write-only; reads return 0x00.
  - 1 MODE: read/write.
  - 2 GPIO_OUT: read/write.
  - 3 GPIO_OE: read/write.
  - 4 GPIO_IN: read-only.
  - 5 STATUS: read-only, read-to-clear. Bit 0 = illegal, bit 1 = abort, bit 2 = timeout, bits 7:3 = 0.
  - 6, 7: illegal.
- States:
  - IDLE: waiting for a command byte.
  - WDATA: waiting for the data byte of a write.
  - RSP: response loaded; waiting for the dummy byte.
- IDLE on rx_valid:
  - Illegal command ([6:3]!=0, or address 6/7): set status.illegal, stay in IDLE, byte dropped.
  - Write to addresses 0..5: go to WDATA and latch the address.
  - Legal read: go to RSP. On the next cycle, tx_byte = register value and tx_load pulses for exactly 1 cycle (latency 1 from rx_valid).
  - gpio_in is sampled in the rx_valid cycle.
- WDATA on rx_valid:
  - The register takes rx_byte on that same clock edge; return to IDLE.
  - CTRL write with data bit0=1: mode, gpio_out, gpio_oe and status return to their reset values; soft_rst pulses high for the 1 following cycle.
  - Write to GPIO_IN or STATUS: data byte consumed and discarded, status.illegal set.
- RSP on rx_valid: byte discarded, return to IDLE.
- STATUS read clears the status bits on the tx_load cycle. An error raised in that same cycle remains set.
- frame_active falling:
  - In WDATA: no write occurs, status.abort set, go to IDLE.
  - In RSP: go to IDLE silently.
  - In IDLE: no effect.
- rx_valid and frame_active falling in the same cycle: the byte is processed first, then the frame-end rule is applied to the resulting state.
- rx_valid while frame_active=0: ignored.
- GPIO registers use the low GPIO_W bits of the data byte. Reads zero-extend.

Optional Feature:
SPI_CMD_TIMEOUT_EN:
- Defined:
  - A counter runs while in WDATA.
  - If TIMEOUT_CYCLES cycles elapse without rx_valid: status.timeout set, return to IDLE, no write.
  - The counter is cleared on entering WDATA.
- Not defined: no counter is built; status bit 2 is constant 0; WDATA is left only on rx_valid or frame end.

Test Plan:
- Write MODE: rx 0x81 then 0x5A in one frame -> busy=1 between the bytes; mode=0x5A on the cycle after the second rx_valid; busy=0.
- Read GPIO_IN: gpio_in=0xC3, rx 0x04 -> one cycle later tx_load=1 for 1 cycle with tx_byte=0xC3; dummy rx byte -> IDLE.
- Abort then status read:
  - rx 0x82, drop frame_active -> gpio_out unchanged; err=1.
  - New frame, rx 0x05 -> tx_byte=0x02; err=0 afterwards.
  - Second STATUS read returns 0x00.
- Illegal cases:
  - rx 0xC2 -> status.illegal=1, stays IDLE.
  - rx 0x84,0xFF -> status.illegal=1, no register change.
- Soft reset: gpio_out=0xAA, mode=0x5A; rx 0x80,0x01 -> soft_rst high 1 cycle; gpio_out=0x00, mode=MODE_RST, status=0.
- Reset mid-write, then timeout:
  - Assert rst low while in WDATA -> all outputs take their reset values immediately, without waiting for a clock edge.
  - With SPI_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=16: rx 0x83, no further bytes -> after 16 cycles, IDLE with status=0x04.
